pipe_stall_ctrl: RTL

Central stall/flush scheduler for the 5-stage pipeline. It merges three things into one consistent set of per-stage stall and flush controls: load-use and branch hazard requests from the hazard detector, a multi-cycle multiply/divide unit (MDU) latency tracker, and data-memory wait states with a timeout. It sits between the hazard detector and the F/D/E/M/W pipeline registers, which consume its outputs directly.

---
 rtl/pipe_stall_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush scheduler: hazards, MDU latency, dmem wait/timeout (optional PIPE_PERF_CNT_EN stall counter)
module pipe_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6,
    parameter int MEM_TO  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HazStall,
    input  logic        HazFlushE,
    input  logic        RedirectD,
    input  logic        MduStartE,
    input  logic        MduOpDivE,
    input  logic        MduUseD,
    input  logic        DMemReqM,
    input  logic        DMemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MduBusy,
    output logic        MduDone,
    output logic        MemErr,
    output logic [31:0] StallCnt
);

    typedef enum logic {M_IDLE, M_BUSY} mduState_t;
    typedef enum logic {W_IDLE, W_WAIT} memState_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       MEM_TO_C = 8'(MEM_TO);

    mduState_t        mState, mNext;
    logic [CNT_W-1:0] mcnt, mcntNext;
    memState_t        wState, wNext;
    logic [7:0]       wcnt, wcntNext;

    logic waitReq, atTimeout, memStall, memTimeout;
    logic mduBusyInt, mduDoneInt, dstall;

    assign waitReq    = DMemReqM && !DMemReadyM;
    assign atTimeout  = (wState == W_WAIT) && (wcnt == MEM_TO_C);
    assign memStall   = waitReq && !atTimeout;
    assign memTimeout = waitReq && atTimeout;
    assign mduBusyInt = (mState == M_BUSY);
    assign mduDoneInt = mduBusyInt && (mcnt == CNT_ONE);
    assign dstall     = HazStall | (MduUseD && mduBusyInt && !mduDoneInt);

    // State registers for both FSMs; reset aborts any MDU op or memory wait
    always_ff @(posedge clk) begin
        if (rst) begin
            mState <= M_IDLE;
            mcnt   <= '0;
            wState <= W_IDLE;
            wcnt   <= '0;
        end else begin
            mState <= mNext;
            mcnt   <= mcntNext;
            wState <= wNext;
            wcnt   <= wcntNext;
        end
    end

    // MDU countdown: runs independently of pipeline stalls once started
    always_comb begin
        mNext    = mState;
        mcntNext = mcnt;
        case (mState)
            M_IDLE: begin
                if (MduStartE && !memStall) begin
                    mNext    = M_BUSY;
                    mcntNext = MduOpDivE ? DIV_LOAD : MUL_LOAD;
                end
            end
            M_BUSY: begin
                mcntNext = mcnt - CNT_ONE;
                if (mcnt == CNT_ONE) begin
                    mNext = M_IDLE;
                end
            end
            default: begin
                mNext    = M_IDLE;
                mcntNext = '0;
            end
        endcase
    end

    // Memory wait tracker with forced release after MEM_TO wait cycles
    always_comb begin
        wNext    = wState;
        wcntNext = wcnt;
        case (wState)
            W_IDLE: begin
                if (waitReq) begin
                    wNext    = W_WAIT;
                    wcntNext = 8'd1;
                end
            end
            W_WAIT: begin
                if (!waitReq || atTimeout) begin
                    wNext    = W_IDLE;
                    wcntNext = 8'd0;
                end else begin
                    wcntNext = wcnt + 8'd1;
                end
            end
            default: begin
                wNext    = W_IDLE;
                wcntNext = 8'd0;
            end
        endcase
    end

    // Stall/flush combine: memory wait freezes everything and bubbles W
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushW  = 1'b0;
        MduBusy = 1'b0;
        MduDone = 1'b0;
        MemErr  = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            MduBusy = mduBusyInt;
            MduDone = mduDoneInt;
            MemErr  = memTimeout;
            if (memStall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = dstall;
                StallD = dstall;
                FlushE = dstall | HazFlushE;
                FlushD = RedirectD && !dstall;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perfCnt;

    // Free-running count of front-end stall cycles, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            perfCnt <= 32'd0;
        end else if (StallF) begin
            perfCnt <= perfCnt + 32'd1;
        end
    end

    assign StallCnt = perfCnt;
`else
    assign StallCnt = 32'd0;
`endif

endmodule
